// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the row-FIFO bank controllers.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int FIFO_DEPTH = 64;
    localparam int FIFO_PTR_W = 7;

    // A burst length of 0 stands for a full-depth burst.
    function automatic logic [FIFO_PTR_W-1:0] decode_len(input logic [FIFO_PTR_W-1:0] enc,
                                                          input int full_depth);
        return (enc == '0) ? FIFO_PTR_W'(full_depth) : enc;
    endfunction

endpackage

// File: rtl/fifo_rd_skew.sv
// Enabled shift register that staggers row read enables by one cycle per row.
module fifo_rd_skew #(
    parameter int row = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           din,
    output logic [row-1:0] q
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!reset_n)
            q <= '0;
        else if (en)
            q <= row'({q, din});
    end

endmodule

// File: rtl/fifo_skew_ctrl.sv
// Skewed read / broadcast write sequencer for the systolic west-edge FIFO bank.
// Define FIFO_SKEW_STALL_EN to stall on empty rows instead of flagging err.
module fifo_skew_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int row   = 8,
    parameter int depth = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [FIFO_PTR_W-1:0] len,
    input  logic                  wr_req,
    input  logic [row-1:0]        fifo_empty,
    input  logic [row-1:0]        fifo_full,
    output logic [row-1:0]        fifo_rd,
    output logic                  fifo_wr,
    output logic                  wr_drop,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                state, state_nxt;
    logic [FIFO_PTR_W-1:0] icnt, len_q;
    logic [row-1:0]        sr, sr_shl;
    logic                  stall, issue, underflow, drain_done, done_nxt;

    assign underflow = |(sr & fifo_empty);
    assign issue     = (state == RUN) && (icnt < len_q);
    assign sr_shl    = sr << 1;
    // With no new issue, the skew register empties on the next shift.
    assign drain_done = ~|sr_shl;

`ifdef FIFO_SKEW_STALL_EN
    assign stall   = underflow;
    assign fifo_rd = sr & ~{row{stall}};
    assign err     = 1'b0;
`else
    assign stall   = 1'b0;
    assign fifo_rd = sr;

    always_ff @(posedge clk) begin
        if (!reset_n)
            err <= 1'b0;
        else if (underflow)
            err <= 1'b1;
    end
`endif

    assign fifo_wr = wr_req & ~|fifo_full;
    assign busy    = (state != IDLE);

    fifo_rd_skew #(.row(row)) u_skew (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~stall),
        .din     (issue),
        .q       (sr)
    );

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_nxt = state;
        done_nxt  = 1'b0;
        if (!stall) begin
            unique case (state)
                IDLE: if (start) state_nxt = RUN;
                RUN: begin
                    if (icnt == len_q) begin
                        if (drain_done) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            icnt    <= '0;
            len_q   <= '0;
            done    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            wr_drop <= wr_req & |fifo_full;
            if (state == IDLE && start) begin
                icnt  <= '0;
                len_q <= decode_len(len, depth);
            end else if (issue && !stall) begin
                icnt <= icnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// Self-checking bench for fifo_skew_ctrl against a progress-counter model and a FIFO bank model.
module tb_fifo_skew_ctrl;

    localparam int ROW   = 8;
    localparam int DEPTH = 64;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic           start   = 1'b0;
    logic           wr_req  = 1'b0;
    logic [6:0]     len     = '0;
    logic [ROW-1:0] fifo_empty, fifo_full, fifo_rd;
    logic           fifo_wr, wr_drop, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_skew_ctrl #(.row(ROW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (len),
        .wr_req     (wr_req),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_rd    (fifo_rd),
        .fifo_wr    (fifo_wr),
        .wr_drop    (wr_drop),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO bank: occupancy per row; a row never moves on a read while empty.
    int             occ [ROW] = '{default: 0};
    logic [ROW-1:0] force_empty   = '0;
    logic           bank_load     = 1'b0;
    int             bank_load_val = 0;

    always_comb begin
        for (int i = 0; i < ROW; i++) begin
            fifo_empty[i] = (occ[i] == 0) || force_empty[i];
            fifo_full[i]  = (occ[i] >= DEPTH);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < ROW; i++) begin
            if (bank_load)
                occ[i] <= bank_load_val;
            else
                occ[i] <= occ[i] + ((fifo_wr && !fifo_full[i]) ? 1 : 0)
                                 - ((fifo_rd[i] && !fifo_empty[i]) ? 1 : 0);
        end
    end

    // Reference model: p counts non-stalled cycles since the start edge; row i is due when 1 <= p-i <= L.
    bit             m_active = 1'b0;
    int             m_p      = 0;
    int             m_len    = 1;
    bit             m_err    = 1'b0;
    bit             m_drop   = 1'b0;
    logic [ROW-1:0] m_due, m_rd;
    logic           m_hit, m_stall, m_busy, m_done, m_wr;

    always_comb begin
        m_due = '0;
        for (int i = 0; i < ROW; i++)
            m_due[i] = m_active && (m_p - i >= 1) && (m_p - i <= m_len);
        m_hit = |(m_due & fifo_empty);
`ifdef FIFO_SKEW_STALL_EN
        m_stall = m_hit;
`else
        m_stall = 1'b0;
`endif
        m_rd   = m_stall ? '0 : m_due;
        m_busy = m_active && (m_p < m_len + ROW);
        m_done = m_active && (m_p == m_len + ROW);
        m_wr   = wr_req && !(|fifo_full);
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_p      <= 0;
            m_err    <= 1'b0;
            m_drop   <= 1'b0;
        end else begin
            m_drop <= wr_req && (|fifo_full);
`ifndef FIFO_SKEW_STALL_EN
            if (m_hit) m_err <= 1'b1;
`endif
            if (m_busy) begin
                if (!m_stall) m_p <= m_p + 1;
            end else if (start) begin
                m_active <= 1'b1;
                m_p      <= 0;
                m_len    <= (len == 7'd0) ? DEPTH : int'(len);
            end else begin
                m_active <= 1'b0;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_fifo_rd", fifo_rd, m_rd);
            check("cyc_fifo_wr", fifo_wr, m_wr);
            check("cyc_wr_drop", wr_drop, m_drop);
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_err", err, m_err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int first_rd [ROW];
    int last_rd  [ROW];
    int done_k, reads, wrs, win_zero, win_hits;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bank_fill(input int v);
        bank_load     = 1'b1;
        bank_load_val = v;
        step();
        bank_load = 1'b0;
    endtask

    // Start a burst and observe it cycle by cycle (k = cycles after the start edge) until done or max_cyc.
    task automatic run_burst(input logic [6:0] l, input int srow, input int sk, input int sn, input int max_cyc);
        start = 1'b1;
        len   = l;
        step();
        start    = 1'b0;
        done_k   = -1;
        reads    = 0;
        wrs      = 0;
        win_zero = 0;
        win_hits = 0;
        for (int i = 0; i < ROW; i++) begin
            first_rd[i] = -1;
            last_rd[i]  = -1;
        end
        for (int k = 0; k < max_cyc && done_k < 0; k++) begin
            bit in_win;
            in_win      = (srow >= 0) && (k >= sk) && (k < sk + sn);
            force_empty = in_win ? (ROW'(1) << srow) : '0;
            @(negedge clk);
            reads += $countones(fifo_rd);
            wrs   += int'(fifo_wr);
            for (int i = 0; i < ROW; i++) begin
                if (fifo_rd[i]) begin
                    if (first_rd[i] < 0) first_rd[i] = k;
                    last_rd[i] = k;
                end
            end
            if (in_win) begin
                if (fifo_rd == '0) win_zero++;
                if (fifo_rd[srow]) win_hits++;
            end
            if (done) done_k = k;
            step();
        end
        force_empty = '0;
    endtask

    typedef struct {
        logic [6:0] len;
        int         exp_done;
        int         exp_reads;
        int         exp_occ;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int wr_cnt, drop_cnt, done_cnt, l_eff;

        vecs[0] = '{7'd4,  12, 32,  60};
        vecs[1] = '{7'd1,  9,  8,   63};
        vecs[2] = '{7'd0,  72, 512, 0};
        vecs[3] = '{7'd17, 25, 136, 47};

        // Reset state; fifo_wr stays combinational on wr_req while in reset.
        reset_n = 1'b0;
        wr_req  = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        check("rst_fifo_rd", fifo_rd, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wr_drop", wr_drop, 1'b0);
        check("rst_fifo_wr", fifo_wr, 1'b1);
        step();
        wr_req  = 1'b0;
        reset_n = 1'b1;
        step();

        // Table of single bursts into a prefilled bank.
        for (int v = 0; v < 4; v++) begin
            l_eff = (vecs[v].len == 7'd0) ? DEPTH : int'(vecs[v].len);
            bank_fill(DEPTH);
            run_burst(vecs[v].len, -1, 0, 0, 200);
            check("tab_done_cycle", done_k, vecs[v].exp_done);
            check("tab_total_reads", reads, vecs[v].exp_reads);
            check("tab_row0_first", first_rd[0], 1);
            check("tab_row0_last", last_rd[0], l_eff);
            check("tab_row7_first", first_rd[ROW-1], ROW);
            check("tab_row7_last", last_rd[ROW-1], l_eff + ROW - 1);
            check("tab_occ_row0", occ[0], vecs[v].exp_occ);
            check("tab_occ_row7", occ[ROW-1], vecs[v].exp_occ);
            @(negedge clk);
            check("tab_all_empty", fifo_empty, (vecs[v].exp_occ == 0) ? {ROW{1'b1}} : {ROW{1'b0}});
            step();
        end

        // Row 3 reports empty for two cycles at its first due read.
        bank_fill(DEPTH);
        run_burst(7'd4, 3, 4, 2, 200);
`ifdef FIFO_SKEW_STALL_EN
        check("stall_done_cycle", done_k, 14);
        check("stall_rd_idle_cycles", win_zero, 2);
        check("stall_no_err", err, 1'b0);
`else
        check("nostall_done_cycle", done_k, 12);
        check("nostall_rd3_asserted", win_hits, 2);
        repeat (5) step();
        @(negedge clk);
        check("nostall_err_sticky", err, 1'b1);
        step();
`endif
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("err_cleared_by_reset", err, 1'b0);
        step();

        // Hold wr_req for 66 cycles into an empty bank.
        bank_fill(0);
        wr_req   = 1'b1;
        wr_cnt   = 0;
        drop_cnt = 0;
        for (int c = 0; c < 68; c++) begin
            if (c == 66) wr_req = 1'b0;
            @(negedge clk);
            wr_cnt   += int'(fifo_wr);
            drop_cnt += int'(wr_drop);
            step();
        end
        check("wr_fill_pulses", wr_cnt, 64);
        check("wr_drop_cycles", drop_cnt, 2);
        check("wr_bank_full", occ[0], DEPTH);

        // Concurrent read burst on the full bank refills exactly len vectors.
        wr_req = 1'b1;
        run_burst(7'd4, -1, 0, 0, 200);
        check("rdwr_done_cycle", done_k, 12);
        check("rdwr_writes", wrs, 4);
        wr_req = 1'b0;
        step();

        // Reset in the middle of a len=8 burst; a second start while busy is ignored.
        bank_fill(DEPTH);
        start = 1'b1;
        len   = 7'd8;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        len   = 7'd1;
        step();
        start = 1'b0;
        step();
        @(negedge clk);
        check("midburst_rd_k3", fifo_rd, 8'b0000_0111);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_fifo_rd", fifo_rd, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("midrst_no_done", done_cnt, 0);
        step();

        // Randomized traffic against the reference model.
        bank_fill(32);
        for (int c = 0; c < 1500; c++) begin
            start       = ($urandom_range(0, 7) == 0);
            len         = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 12));
            wr_req      = ($urandom_range(0, 1) == 1);
            force_empty = ($urandom_range(0, 11) == 0) ? (ROW'(1) << $urandom_range(0, ROW - 1)) : '0;
            reset_n     = ($urandom_range(0, 399) != 0);
            step();
        end
        start       = 1'b0;
        wr_req      = 1'b0;
        force_empty = '0;
        reset_n     = 1'b1;
        repeat (4) step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
